// File: rtl/pc_redirect_if.sv
// Bundle between jump control / register file / icache and the PC redirect unit.
// The master drives the redirect request and stall; the slave returns the fetch PC and pulses.
interface pc_redirect_if #(
    parameter int ADDR_W = 32
);
    logic [1:0]        JumpOP;
    logic [ADDR_W-1:0] sign_imm;
    logic [25:0]       jump_addr;
    logic [ADDR_W-1:0] rs_data;
    logic              stall;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] pc_plus4;
    logic              flush;
    logic              redirect_pending;
    logic              misalign;

    modport master (
        output JumpOP, sign_imm, jump_addr, rs_data, stall,
        input  pc_out, pc_plus4, flush, redirect_pending, misalign
    );

    modport slave (
        input  JumpOP, sign_imm, jump_addr, rs_data, stall,
        output pc_out, pc_plus4, flush, redirect_pending, misalign
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// Program counter with next-PC selection. A redirect that arrives while the icache
// stalls is captured and applied when the stall clears.
//
//  state | meaning
//  RUN   | normal fetch; redirects apply on the next edge unless stalled
//  HOLD  | redirect captured during a stall; waiting for stall to clear
module pc_redirect_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    pc_redirect_if.slave bus
);
    typedef enum logic {RUN, HOLD} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pend_pc;
    logic [ADDR_W-1:0] plus4;
    logic [ADDR_W-1:0] target;
    logic              raw_misalign;
    logic              flush_q;
    logic              misalign_q;

    assign plus4        = pc_q + ADDR_W'(4);
    assign raw_misalign = (bus.rs_data[1:0] != 2'b00);

    always_comb begin
        target = plus4;
        unique case (bus.JumpOP)
            2'b00: target = plus4;
            2'b01: target = plus4 + (bus.sign_imm << 2);
            2'b10: target = {bus.rs_data[ADDR_W-1:2], 2'b00};
            2'b11: target = {plus4[ADDR_W-1:28], bus.jump_addr, 2'b00};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pc_q       <= RESET_PC;
            pend_pc    <= '0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (!bus.stall) begin
                        pc_q       <= target;
                        flush_q    <= (bus.JumpOP != 2'b00);
                        misalign_q <= (bus.JumpOP == 2'b10) && raw_misalign;
                    end else if (bus.JumpOP == 2'b00) begin
                        flush_q    <= 1'b0;
                        misalign_q <= 1'b0;
                    end else begin
                        // Target is frozen here; later operand changes must not move it.
                        pend_pc    <= target;
                        flush_q    <= 1'b0;
                        misalign_q <= (bus.JumpOP == 2'b10) && raw_misalign;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    misalign_q <= 1'b0;
                    if (bus.stall) begin
                        flush_q <= 1'b0;
                    end else begin
                        pc_q    <= pend_pc;
                        flush_q <= 1'b1;
                        state   <= RUN;
                    end
                end
            endcase
        end
    end

    assign bus.pc_out           = pc_q;
    assign bus.pc_plus4         = plus4;
    assign bus.flush            = flush_q;
    assign bus.misalign         = misalign_q;
    assign bus.redirect_pending = (state == HOLD);
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: driver pushes expected outputs per edge,
// an independent monitor pops and compares one cycle later.
module tb_pc_redirect_unit;
    localparam int          AW  = 32;
    localparam logic [31:0] RPC = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        mis;
        logic        pend;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_redirect_if #(.ADDR_W(AW)) bus ();

    pc_redirect_unit #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    logic [31:0] m_pc;
    bit          m_hold;
    logic [31:0] m_tgt;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Called positioned at a negedge; drives one cycle of stimulus and returns at the next negedge.
    task automatic step(input logic [1:0] op, input logic [31:0] imm, input logic [25:0] ja,
                        input logic [31:0] rs, input logic st);
        exp_t        e;
        logic [31:0] tgt;
        bus.JumpOP    = op;
        bus.sign_imm  = imm;
        bus.jump_addr = ja;
        bus.rs_data   = rs;
        bus.stall     = st;
        case (op)
            2'd0:    tgt = m_pc + 32'd4;
            2'd1:    tgt = m_pc + 32'd4 + imm * 32'd4;
            2'd2:    tgt = rs & 32'hFFFF_FFFC;
            default: tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'b0, ja} * 32'd4);
        endcase
        e.flush = 1'b0;
        e.mis   = 1'b0;
        if (!m_hold) begin
            if (!st) begin
                m_pc    = tgt;
                e.flush = (op != 2'd0);
                e.mis   = (op == 2'd2) && (rs % 4 != 0);
            end else if (op != 2'd0) begin
                m_hold = 1'b1;
                m_tgt  = tgt;
                e.mis  = (op == 2'd2) && (rs % 4 != 0);
            end
        end else if (!st) begin
            m_pc    = m_tgt;
            m_hold  = 1'b0;
            e.flush = 1'b1;
        end
        e.pc   = m_pc;
        e.pend = m_hold;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic seq(input logic st);
        step(2'd0, 32'h0, 26'h0, 32'h0, st);
    endtask

    task automatic go_to(input logic [31:0] a);
        step(2'd2, 32'h0, 26'h0, a, 1'b0);
    endtask

    // Asserts rst mid-cycle and checks the asynchronous effect before any clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_pc_out", bus.pc_out, RPC);
        chk("rst_flush", {31'b0, bus.flush}, 32'd0);
        chk("rst_misalign", {31'b0, bus.misalign}, 32'd0);
        chk("rst_pending", {31'b0, bus.redirect_pending}, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        m_pc   = RPC;
        m_hold = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_out", bus.pc_out, e.pc);
                chk("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
                chk("flush", {31'b0, bus.flush}, {31'b0, e.flush});
                chk("misalign", {31'b0, bus.misalign}, {31'b0, e.mis});
                chk("redirect_pending", {31'b0, bus.redirect_pending}, {31'b0, e.pend});
            end
        end
    end

    initial begin : driver
        logic [1:0]  op;
        logic [31:0] imm;
        bus.JumpOP    = 2'd0;
        bus.sign_imm  = '0;
        bus.jump_addr = '0;
        bus.rs_data   = '0;
        bus.stall     = 1'b0;
        m_pc   = RPC;
        m_hold = 1'b0;
        m_tgt  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: mid-cycle reset then sequential fetch
        do_reset();
        repeat (3) seq(1'b0);

        // 2: branches backward and forward
        go_to(32'h100);
        step(2'd1, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0);
        seq(1'b0);
        go_to(32'h100);
        step(2'd1, 32'h3, 26'h0, 32'h0, 1'b0);
        seq(1'b0);

        // 3: absolute and register jumps
        go_to(32'h4000_0010);
        step(2'd3, 32'h0, 26'h40, 32'h0, 1'b0);
        step(2'd2, 32'h0, 26'h0, 32'h2006, 1'b0);
        seq(1'b0);

        // 4: redirect during stall, operands changing while held
        go_to(32'h200);
        step(2'd1, 32'h4, 26'h0, 32'h0, 1'b1);
        step(2'd3, 32'h55, 26'h3FF, 32'h1237, 1'b1);
        repeat (3) seq(1'b1);
        seq(1'b0);
        seq(1'b0);

        // 5: reset while holding
        go_to(32'h200);
        step(2'd1, 32'h4, 26'h0, 32'h0, 1'b1);
        seq(1'b1);
        do_reset();
        repeat (3) seq(1'b0);

        // 6: wrap and stall release coinciding with a jump
        go_to(32'hFFFF_FFFC);
        seq(1'b0);
        seq(1'b1);
        step(2'd3, 32'h0, 26'h123, 32'h0, 1'b0);
        seq(1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                op  = 2'($urandom_range(0, 3));
                imm = ($urandom_range(0, 1) == 1) ? 32'($urandom)
                                                  : 32'(signed'(16'($urandom)));
                step(op, imm, 26'($urandom), 32'($urandom), ($urandom_range(0, 9) < 3));
            end
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
Program-counter register and next-PC selector. Consumes the 2-bit JumpOP redirect code from the jump control decoder and turns it into a registered fetch address. Honours an instruction-cache stall, and holds a redirect that arrives during a stall until the stall clears. Sits between jump control, the register file (jr/jalr source), and the instruction-cache fetch port.

Parameters:
ADDR_W, 32, PC and target width (ADDR_W ≥ 30)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
JumpOP  input  2  redirect code: 00 sequential, 01 taken branch, 10 register jump (jr/jalr), 11 absolute jump (j/jal)
sign_imm  input  ADDR_W  sign-extended 16-bit branch immediate
jump_addr  input  26  instr[25:0] jump index
rs_data  input  ADDR_W  register value for jr/jalr
stall  input  1  fetch stall (icache miss); PC must not advance
pc_out  output  ADDR_W  current fetch address (registered)
pc_plus4  output  ADDR_W  pc_out+4, combinational; link value for jal/jalr
flush  output  1  one-cycle pulse: squash the wrong-path instruction in decode
redirect_pending  output  1  high while a redirect is held in HOLD
misalign  output  1  one-cycle pulse: register target had bits[1:0]≠0

Behaviour:
- Reset (async, any time, including during HOLD):
  - pc_out=RESET_PC; flush=0; misalign=0; redirect_pending=0; state=RUN; pend_pc=0.
- Target computation (combinational, from current pc_out):
  - 00: pc_plus4.
  - 01: pc_plus4 + (sign_imm<<2), modulo 2^ADDR_W.
  - 11: {pc_plus4[ADDR_W-1:28], jump_addr, 2'b00}.
  - 10: {rs_data[ADDR_W-1:2], 2'b00}; raw_misalign = (rs_data[1:0]≠0).
- State RUN:
  - stall=0: on the edge, pc_out←target.
    - flush←(JumpOP≠00).
    - misalign←(JumpOP==10 & raw_misalign).
    - Latency: one cycle from JumpOP to the new pc_out.
  - stall=1, JumpOP=00: pc_out holds; flush←0; stay in RUN.
  - stall=1, JumpOP≠00: pc_out holds; pend_pc←target; misalign←(JumpOP==10 & raw_misalign); flush←0; go to HOLD.
- State HOLD (redirect_pending=1):
  - JumpOP, sign_imm, jump_addr and rs_data are ignored. The captured target is final even if Zero or rs_data change during the stall.
  - stall=1: hold pc_out; flush←0; misalign←0.
  - stall=0: pc_out←pend_pc; flush←1; go to RUN.
- flush and misalign are never high for more than one consecutive cycle per redirect. misalign never re-pulses on the HOLD release.
- Wrap-around: pc_plus4 of 0xFFFF_FFFC is 0x0000_0000. Branch targets wrap silently with no flag.
- stall deasserting in the same cycle a new JumpOP arrives in RUN is handled as the stall=0 case. The redirect is applied directly, with no HOLD.
- The PC always stays word-aligned. pc_out[1:0]=00 in every cycle.

Test Plan:
1. Reset and sequential fetch: assert rst mid-cycle, release; JumpOP=00, stall=0 for 3 edges -> pc_out 0x0, 0x4, 0x8, 0xC; flush=0 throughout.
2. Branch:
   - pc_out=0x100, JumpOP=01, sign_imm=0xFFFF_FFFE -> next pc_out=0x0FC, flush=1 for exactly one cycle.
   - Same with sign_imm=0x3 -> pc_out=0x110.
3. Absolute and register jumps:
   - pc_out=0x4000_0010, JumpOP=11, jump_addr=0x0000040 -> pc_out=0x4000_0100.
   - JumpOP=10, rs_data=0x0000_2006 -> pc_out=0x2004, misalign=1 for one cycle.
4. Redirect during stall: pc_out=0x200, stall=1, JumpOP=01, sign_imm=0x4 for 1 cycle. Then JumpOP=00 with stall=1 for 4 cycles, then stall=0 -> pc_out stays 0x200, redirect_pending=1 during stall; on release pc_out=0x214, flush=1 once, pending=0.
5. Reset mid-HOLD: enter HOLD as in test 4, assert rst while stall=1 -> pc_out=RESET_PC, redirect_pending=0. After release with stall=0 the PC steps sequentially and the held target is never applied.
6. Wrap and simultaneous release: pc_out=0xFFFF_FFFC, JumpOP=00 -> pc_out=0x0. In RUN with stall falling in the same cycle as JumpOP=11 -> redirect applied next edge, redirect_pending never asserted.
